// File: rtl/bot_pkg.sv
// Shared definitions for the bot motion stack: turn action codes, sequencer
// states and the path terminator node id.
package bot_pkg;

  typedef enum logic [1:0] {
    ACT_FOLLOW   = 2'b00,
    ACT_RIGHT    = 2'b01,
    ACT_LEFT     = 2'b10,
    ACT_STRAIGHT = 2'b11
  } action_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FOLLOW,
    S_ISSUE,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [6:0] END_MARK_DEFAULT = 7'h7F;

endpackage

// File: rtl/path_sequencer_node_timer.sv
// node_edge_timer: registered rising-edge detect on the node marker level plus
// the watchdog counting cycles spent following a line without reaching a node.
module node_edge_timer #(
  parameter int unsigned NODE_TMO = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic node_seen,
  input  logic cnt_en,
  input  logic cnt_clr,
  output logic node_rise,
  output logic tmo_expired
);

  localparam int CNT_W = (NODE_TMO > 1) ? $clog2(NODE_TMO + 1) : 1;
  localparam int unsigned TMO_LAST = (NODE_TMO == 0) ? 0 : NODE_TMO - 1;
  localparam bit TMO_ON = (NODE_TMO != 0);

  logic             seen_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      seen_q <= node_seen;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_en && TMO_ON) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign node_rise = node_seen && !seen_q;

  // Fires in the cycle whose increment brings the count to NODE_TMO.
  assign tmo_expired = TMO_ON && cnt_en && !cnt_clr && (cnt_q == CNT_W'(TMO_LAST));

endmodule

// File: rtl/path_sequencer.sv
// path_sequencer: latches a planned node path with per-hop turn codes, counts
// node crossings and hands one turn command per node to the motion block.
module path_sequencer
  import bot_pkg::*;
#(
  parameter int              NODE_W    = 7,
  parameter int              MAX_NODES = 36,
  parameter logic [NODE_W-1:0] END_MARK = END_MARK_DEFAULT,
  parameter int unsigned     NODE_TMO  = 50000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        path_valid,
  output logic                        path_ready,
  input  logic [NODE_W*MAX_NODES-1:0] path_data,
  input  logic [2*MAX_NODES-1:0]      turn_data,
  input  logic                        node_seen,
  input  logic                        abort,
  output logic [NODE_W-1:0]           cur_node,
  output logic [NODE_W-1:0]           next_node,
  output logic [1:0]                  action,
  output logic                        action_valid,
  input  logic                        action_ack,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int IDX_W = $clog2(MAX_NODES + 1);

  state_e                             state_q, state_d;
  logic [MAX_NODES-1:0][NODE_W-1:0]   path_q;
  logic [MAX_NODES-1:0][1:0]          turn_q;
  logic [IDX_W-1:0]                   len_q, len_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NODE_W-1:0]                  cur_q, cur_d;
  logic [NODE_W-1:0]                  next_q, next_d;
  action_e                            act_q, act_d;
  logic                               valid_q, valid_d;
  logic                               load_path;
  logic [IDX_W-1:0]                   len_scan;
  logic [IDX_W-1:0]                   idx_p1, idx_p2, len_m1;
  logic                               node_rise, tmo_expired;
  logic                               cnt_en, cnt_clr;

  // Path length is the first terminator slot; a path with none fills every slot.
  always_comb begin
    len_scan = IDX_W'(MAX_NODES);
    for (int k = MAX_NODES - 1; k >= 0; k--) begin
      if (path_data[k*NODE_W +: NODE_W] == END_MARK) len_scan = IDX_W'(k);
    end
  end

  assign idx_p1 = idx_q + IDX_W'(1);
  assign idx_p2 = idx_q + IDX_W'(2);
  assign len_m1 = len_q - IDX_W'(1);

  assign cnt_en  = (state_q == S_FOLLOW) && !abort;
  assign cnt_clr = !cnt_en || node_rise;

  node_edge_timer #(
    .NODE_TMO (NODE_TMO)
  ) u_node_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .node_seen   (node_seen),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .node_rise   (node_rise),
    .tmo_expired (tmo_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    next_d    = next_q;
    act_d     = act_q;
    valid_d   = valid_q;
    load_path = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      len_d   = '0;
      idx_d   = '0;
      cur_d   = '0;
      next_d  = '0;
      act_d   = ACT_FOLLOW;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (path_valid) begin
            load_path = 1'b1;
            len_d     = len_scan;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          if (len_q < IDX_W'(2)) begin
            state_d = S_ERROR;
          end else begin
            idx_d   = '0;
            cur_d   = path_q[0];
            next_d  = path_q[1];
            act_d   = ACT_FOLLOW;
            valid_d = 1'b0;
            state_d = S_FOLLOW;
          end
        end
        S_FOLLOW: begin
          act_d   = ACT_FOLLOW;
          valid_d = 1'b0;
          // A node arrival takes precedence over a timeout in the same cycle.
          if (node_rise) begin
            idx_d = idx_p1;
            cur_d = path_q[idx_p1];
            if (idx_p1 == len_m1) begin
              state_d = S_DONE;
            end else begin
              next_d  = path_q[idx_p2];
              act_d   = action_e'(turn_q[idx_p1]);
              valid_d = 1'b1;
              state_d = S_ISSUE;
            end
          end else if (tmo_expired) begin
            state_d = S_ERROR;
          end
        end
        S_ISSUE: begin
          if (action_ack) begin
            act_d   = ACT_FOLLOW;
            valid_d = 1'b0;
            state_d = S_FOLLOW;
          end
        end
        S_DONE, S_ERROR: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: the path and turn stores are plain registers and are reset with
  // everything else, so no stale route survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      path_q  <= '0;
      turn_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      act_q   <= ACT_FOLLOW;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      act_q   <= act_d;
      valid_q <= valid_d;
      if (load_path) begin
        path_q <= path_data;
        turn_q <= turn_data;
      end
    end
  end

  assign path_ready   = (state_q == S_IDLE);
  assign busy         = (state_q == S_LOAD) || (state_q == S_FOLLOW) || (state_q == S_ISSUE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign cur_node     = cur_q;
  assign next_node    = next_q;
  assign action       = act_q;
  assign action_valid = valid_q;

endmodule
